// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename status (busy + producing ROB tag).
// Commits write data in order; dispatch reads resolve to a value, a commit bypass, or a pending tag.
module reg_file_rename #(
   parameter int unsigned REG_NUM = 32,
   parameter int unsigned REG_W   = 5,
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              clear,
   input  logic              ID_valid,
   input  logic [REG_W-1:0]  ID_dest_reg,
   input  logic [TAG_W-1:0]  ID_tag,
   input  logic              CDB_data_valid,
   input  logic [REG_W-1:0]  CDB_reg_dest,
   input  logic [TAG_W-1:0]  CDB_tag,
   input  logic [DATA_W-1:0] CDB_data,
   input  logic [REG_W-1:0]  dispatch_rs1,
   input  logic [REG_W-1:0]  dispatch_rs2,
   output logic              dispatch_reg1_valid,
   output logic [DATA_W-1:0] dispatch_reg1_data,
   output logic [TAG_W-1:0]  dispatch_reg1_tag,
   output logic              dispatch_reg2_valid,
   output logic [DATA_W-1:0] dispatch_reg2_data,
   output logic [TAG_W-1:0]  dispatch_reg2_tag
);

   localparam int unsigned NUM_PORTS = 2;

   logic [DATA_W-1:0] r_data [REG_NUM];
   logic [TAG_W-1:0]  r_tag  [REG_NUM];
   logic [REG_NUM-1:0] r_busy;

   logic w_commit;
   logic w_rename;

   logic [REG_W-1:0]  w_rs    [NUM_PORTS];
   logic              w_valid [NUM_PORTS];
   logic [DATA_W-1:0] w_data  [NUM_PORTS];
   logic [TAG_W-1:0]  w_tag   [NUM_PORTS];

   // x0 is never a write target, so it stays zero and never busy
   assign w_commit = CDB_data_valid && (CDB_reg_dest != '0);
   assign w_rename = ID_valid && (ID_dest_reg != '0);

   // State update: commit clears busy on tag match, clear drops all busy, rename overrides last
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '{default: '0};
         r_tag  <= '{default: '0};
         r_busy <= '0;
      end else if (rdy) begin
         if (w_commit) begin
            r_data[CDB_reg_dest] <= CDB_data;
            if (r_busy[CDB_reg_dest] && (r_tag[CDB_reg_dest] == CDB_tag)) begin
               r_busy[CDB_reg_dest] <= 1'b0;
            end
         end
         if (clear) begin
            r_busy <= '0;
         end else if (w_rename) begin
            r_busy[ID_dest_reg] <= 1'b1;
            r_tag[ID_dest_reg]  <= ID_tag;
         end
      end
   end

   assign w_rs[0] = dispatch_rs1;
   assign w_rs[1] = dispatch_rs2;

   // Read resolution from pre-edge state with same-cycle commit bypass
   always_comb begin
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
         w_valid[p] = 1'b1;
         w_data[p]  = '0;
         w_tag[p]   = '0;
         if (w_rs[p] == '0) begin
            w_valid[p] = 1'b1;
         end else if (!r_busy[w_rs[p]]) begin
            w_data[p] = r_data[w_rs[p]];
         end else if (CDB_data_valid && (CDB_reg_dest == w_rs[p]) &&
                      (CDB_tag == r_tag[w_rs[p]])) begin
            w_data[p] = CDB_data;
         end else begin
            w_valid[p] = 1'b0;
            w_tag[p]   = r_tag[w_rs[p]];
         end
      end
   end

   assign dispatch_reg1_valid = w_valid[0];
   assign dispatch_reg1_data  = w_data[0];
   assign dispatch_reg1_tag   = w_tag[0];
   assign dispatch_reg2_valid = w_valid[1];
   assign dispatch_reg2_data  = w_data[1];
   assign dispatch_reg2_tag   = w_tag[1];

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed self-checking bench for reg_file_rename: rename, commit, bypass, clear, x0, rdy and reset.
module tb_reg_file_rename;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        clear;
   logic        ID_valid;
   logic [4:0]  ID_dest_reg;
   logic [3:0]  ID_tag;
   logic        CDB_data_valid;
   logic [4:0]  CDB_reg_dest;
   logic [3:0]  CDB_tag;
   logic [31:0] CDB_data;
   logic [4:0]  dispatch_rs1;
   logic [4:0]  dispatch_rs2;
   logic        dispatch_reg1_valid;
   logic [31:0] dispatch_reg1_data;
   logic [3:0]  dispatch_reg1_tag;
   logic        dispatch_reg2_valid;
   logic [31:0] dispatch_reg2_data;
   logic [3:0]  dispatch_reg2_tag;

   int vectors;
   int miscompares;
   logic [36:0] r1;
   logic [36:0] r2;
   logic [36:0] exp1;
   logic [36:0] exp2;

   reg_file_rename dut (
      .clk                 (clk),
      .rst                 (rst),
      .rdy                 (rdy),
      .clear               (clear),
      .ID_valid            (ID_valid),
      .ID_dest_reg         (ID_dest_reg),
      .ID_tag              (ID_tag),
      .CDB_data_valid      (CDB_data_valid),
      .CDB_reg_dest        (CDB_reg_dest),
      .CDB_tag             (CDB_tag),
      .CDB_data            (CDB_data),
      .dispatch_rs1        (dispatch_rs1),
      .dispatch_rs2        (dispatch_rs2),
      .dispatch_reg1_valid (dispatch_reg1_valid),
      .dispatch_reg1_data  (dispatch_reg1_data),
      .dispatch_reg1_tag   (dispatch_reg1_tag),
      .dispatch_reg2_valid (dispatch_reg2_valid),
      .dispatch_reg2_data  (dispatch_reg2_data),
      .dispatch_reg2_tag   (dispatch_reg2_tag)
   );

   assign r1 = {dispatch_reg1_valid, dispatch_reg1_data, dispatch_reg1_tag};
   assign r2 = {dispatch_reg2_valid, dispatch_reg2_data, dispatch_reg2_tag};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst            = 1'b0;
      rdy            = 1'b1;
      clear          = 1'b0;
      ID_valid       = 1'b0;
      ID_dest_reg    = '0;
      ID_tag         = '0;
      CDB_data_valid = 1'b0;
      CDB_reg_dest   = '0;
      CDB_tag        = '0;
      CDB_data       = '0;
   endtask

   task automatic rename(input logic [4:0] r, input logic [3:0] t);
      idle();
      ID_valid = 1'b1; ID_dest_reg = r; ID_tag = t;
      tick();
      idle();
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      tick(); tick();
      idle();
      dispatch_rs1 = 5'd5; dispatch_rs2 = 5'd0; #1;
      exp1 = {1'b1, 32'h0, 4'h0}; exp2 = {1'b1, 32'h0, 4'h0};
      vectors++;
      if (r1 !== exp1) begin miscompares++; $display("FAIL reset_rs1: got %h want %h", r1, exp1); end
      vectors++;
      if (r2 !== exp2) begin miscompares++; $display("FAIL reset_rs2: got %h want %h", r2, exp2); end
   endtask

   task automatic test_rename_commit();
      idle();
      ID_valid = 1'b1; ID_dest_reg = 5'd3; ID_tag = 4'd7;
      dispatch_rs1 = 5'd3; #1;
      exp1 = {1'b1, 32'h0, 4'h0};
      vectors++;
      if (r1 !== exp1) begin miscompares++; $display("FAIL own_rename_invisible: got %h want %h", r1, exp1); end
      tick(); idle(); #1;
      exp1 = {1'b0, 32'h0, 4'h7};
      vectors++;
      if (r1 !== exp1) begin miscompares++; $display("FAIL pending_x3: got %h want %h", r1, exp1); end
      CDB_data_valid = 1'b1; CDB_reg_dest = 5'd3; CDB_tag = 4'd7; CDB_data = 32'hDEADBEEF; #1;
      exp1 = {1'b1, 32'hDEADBEEF, 4'h0};
      vectors++;
      if (r1 !== exp1) begin miscompares++; $display("FAIL bypass_x3: got %h want %h", r1, exp1); end
      tick(); idle(); #1;
      vectors++;
      if (r1 !== exp1) begin miscompares++; $display("FAIL stored_x3: got %h want %h", r1, exp1); end
   endtask

   task automatic test_younger_rename();
      rename(5'd4, 4'd2);
      rename(5'd4, 4'd9);
      CDB_data_valid = 1'b1; CDB_reg_dest = 5'd4; CDB_tag = 4'd2; CDB_data = 32'h11;
      dispatch_rs1 = 5'd4; #1;
      exp1 = {1'b0, 32'h0, 4'h9};
      vectors++;
      if (r1 !== exp1) begin miscompares++; $display("FAIL stale_commit_no_bypass: got %h want %h", r1, exp1); end
      tick(); idle(); #1;
      vectors++;
      if (r1 !== exp1) begin miscompares++; $display("FAIL x4_still_busy: got %h want %h", r1, exp1); end
      CDB_data_valid = 1'b1; CDB_reg_dest = 5'd4; CDB_tag = 4'd9; CDB_data = 32'h22;
      tick(); idle(); #1;
      exp1 = {1'b1, 32'h22, 4'h0};
      vectors++;
      if (r1 !== exp1) begin miscompares++; $display("FAIL x4_final: got %h want %h", r1, exp1); end
   endtask

   task automatic test_same_cycle();
      rename(5'd6, 4'd1);
      CDB_data_valid = 1'b1; CDB_reg_dest = 5'd6; CDB_tag = 4'd1; CDB_data = 32'h55;
      ID_valid = 1'b1; ID_dest_reg = 5'd6; ID_tag = 4'd3;
      dispatch_rs1 = 5'd6; #1;
      exp1 = {1'b1, 32'h55, 4'h0};
      vectors++;
      if (r1 !== exp1) begin miscompares++; $display("FAIL x6_bypass: got %h want %h", r1, exp1); end
      tick(); idle(); #1;
      exp1 = {1'b0, 32'h0, 4'h3};
      vectors++;
      if (r1 !== exp1) begin miscompares++; $display("FAIL x6_rename_wins: got %h want %h", r1, exp1); end
      clear = 1'b1;
      tick(); idle(); #1;
      exp1 = {1'b1, 32'h55, 4'h0};
      vectors++;
      if (r1 !== exp1) begin miscompares++; $display("FAIL x6_data_kept: got %h want %h", r1, exp1); end
   endtask

   task automatic test_clear();
      CDB_data_valid = 1'b1; CDB_reg_dest = 5'd1; CDB_tag = 4'd0; CDB_data = 32'hAAAA0001;
      tick(); idle();
      rename(5'd1, 4'd4);
      rename(5'd2, 4'd5);
      rename(5'd10, 4'd6);
      dispatch_rs1 = 5'd1; dispatch_rs2 = 5'd10; #1;
      exp1 = {1'b0, 32'h0, 4'h4}; exp2 = {1'b0, 32'h0, 4'h6};
      vectors++;
      if (r1 !== exp1) begin miscompares++; $display("FAIL x1_pending: got %h want %h", r1, exp1); end
      vectors++;
      if (r2 !== exp2) begin miscompares++; $display("FAIL x10_pending: got %h want %h", r2, exp2); end
      clear = 1'b1;
      ID_valid = 1'b1; ID_dest_reg = 5'd11; ID_tag = 4'd8;
      CDB_data_valid = 1'b1; CDB_reg_dest = 5'd12; CDB_tag = 4'd0; CDB_data = 32'h99;
      tick(); idle();
      dispatch_rs1 = 5'd1; dispatch_rs2 = 5'd2; #1;
      exp1 = {1'b1, 32'hAAAA0001, 4'h0}; exp2 = {1'b1, 32'h0, 4'h0};
      vectors++;
      if (r1 !== exp1) begin miscompares++; $display("FAIL clear_x1: got %h want %h", r1, exp1); end
      vectors++;
      if (r2 !== exp2) begin miscompares++; $display("FAIL clear_x2: got %h want %h", r2, exp2); end
      dispatch_rs1 = 5'd10; dispatch_rs2 = 5'd11; #1;
      vectors++;
      if (r1 !== exp2) begin miscompares++; $display("FAIL clear_x10: got %h want %h", r1, exp2); end
      vectors++;
      if (r2 !== exp2) begin miscompares++; $display("FAIL clear_drops_x11: got %h want %h", r2, exp2); end
      dispatch_rs1 = 5'd12; dispatch_rs2 = 5'd3; #1;
      exp1 = {1'b1, 32'h99, 4'h0}; exp2 = {1'b1, 32'hDEADBEEF, 4'h0};
      vectors++;
      if (r1 !== exp1) begin miscompares++; $display("FAIL clear_commit_x12: got %h want %h", r1, exp1); end
      vectors++;
      if (r2 !== exp2) begin miscompares++; $display("FAIL x3_intact: got %h want %h", r2, exp2); end
   endtask

   task automatic test_x0_and_rdy();
      CDB_data_valid = 1'b1; CDB_reg_dest = 5'd0; CDB_tag = 4'd3; CDB_data = 32'hFFFFFFFF;
      ID_valid = 1'b1; ID_dest_reg = 5'd0; ID_tag = 4'd3;
      dispatch_rs1 = 5'd0; dispatch_rs2 = 5'd0; #1;
      exp1 = {1'b1, 32'h0, 4'h0};
      vectors++;
      if (r1 !== exp1) begin miscompares++; $display("FAIL x0_same_cycle: got %h want %h", r1, exp1); end
      tick(); idle(); #1;
      vectors++;
      if (r2 !== exp1) begin miscompares++; $display("FAIL x0_after: got %h want %h", r2, exp1); end
      rdy = 1'b0;
      ID_valid = 1'b1; ID_dest_reg = 5'd8; ID_tag = 4'd5;
      CDB_data_valid = 1'b1; CDB_reg_dest = 5'd12; CDB_tag = 4'd0; CDB_data = 32'h1234;
      tick(); idle();
      dispatch_rs1 = 5'd8; dispatch_rs2 = 5'd12; #1;
      exp2 = {1'b1, 32'h99, 4'h0};
      vectors++;
      if (r1 !== exp1) begin miscompares++; $display("FAIL rdy_hold_x8: got %h want %h", r1, exp1); end
      vectors++;
      if (r2 !== exp2) begin miscompares++; $display("FAIL rdy_hold_x12: got %h want %h", r2, exp2); end
   endtask

   task automatic test_reset_priority();
      rename(5'd9, 4'd1);
      rst = 1'b1;
      ID_valid = 1'b1; ID_dest_reg = 5'd5; ID_tag = 4'd2;
      CDB_data_valid = 1'b1; CDB_reg_dest = 5'd7; CDB_tag = 4'd0; CDB_data = 32'h77;
      tick(); idle();
      exp1 = {1'b1, 32'h0, 4'h0};
      dispatch_rs1 = 5'd9; dispatch_rs2 = 5'd5; #1;
      vectors++;
      if (r1 !== exp1) begin miscompares++; $display("FAIL rst_x9: got %h want %h", r1, exp1); end
      vectors++;
      if (r2 !== exp1) begin miscompares++; $display("FAIL rst_x5: got %h want %h", r2, exp1); end
      dispatch_rs1 = 5'd7; dispatch_rs2 = 5'd3; #1;
      vectors++;
      if (r1 !== exp1) begin miscompares++; $display("FAIL rst_x7: got %h want %h", r1, exp1); end
      vectors++;
      if (r2 !== exp1) begin miscompares++; $display("FAIL rst_x3: got %h want %h", r2, exp1); end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      dispatch_rs1 = '0;
      dispatch_rs2 = '0;
      idle();
      test_reset();
      test_rename_commit();
      test_younger_rename();
      test_same_cycle();
      test_clear();
      test_x0_and_rdy();
      test_reset_priority();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
